muldiv_sequencer: RTL and testbench

Multi-cycle controller that owns the HI/LO register pair and sequences iterative multiply and divide on behalf of the pipeline's execute stage. It accepts one operation at a time over a start/ready handshake and runs a shift-add multiplier or a restoring divider for DATA_WIDTH iterations. It then writes HI/LO and pulses done. The ALU reads HI/LO from this block for mfhi/mflo; the pipeline stalls on busy.

---
 rtl/muldiv_sequencer.sv | 268 ++++++++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: owns HI/LO and sequences iterative multiply (shift-add) and
// divide (restoring), one operation at a time over a start/ready handshake.
// Optional single-cycle multiplier enabled by defining MULDIV_FAST_MUL_EN.
//
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   start, op, rs, rt  request and operands, sampled when ready=1
//                      op: 000 mult, 001 multu, 010 div, 011 divu,
//                          100 mthi, 101 mtlo, 11x reserved (no effect)
//   flush              abort any in-flight operation; blocks acceptance
//   ready              start accepted this cycle (IDLE and no flush)
//   busy               iterative operation in flight
//   done               one-cycle pulse when HI/LO updated by mult/div
//   hi, lo             HI/LO registers
module muldiv_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [OP_WIDTH-1:0]   op,
  input  logic [DATA_WIDTH-1:0] rs,
  input  logic [DATA_WIDTH-1:0] rt,
  input  logic                  flush,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  localparam logic [OP_WIDTH-1:0] OP_MULT  = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_MULTU = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_DIV   = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_DIVU  = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_MTHI  = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_MTLO  = OP_WIDTH'(5);

  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  // Multiply: {partial product high, multiplier shifting out low}.
  // Divide:   {partial remainder, dividend shifting into quotient}.
  logic [2*W-1:0]  acc_q, acc_d;
  logic [W-1:0]    opb_q, opb_d;     // multiplicand or divisor magnitude
  logic            is_div_q, is_div_d;
  logic            neg_q, neg_d;     // negate product / quotient
  logic            rneg_q, rneg_d;   // negate remainder (dividend sign)
  logic            dbz_q, dbz_d;     // divide by zero
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;
  logic            done_q, done_d;

  // Request decode and operand magnitudes
  logic            op_mul, op_div, op_signed;
  logic            rs_neg, rt_neg;
  logic [W-1:0]    rs_mag, rt_mag;

  // One iteration of each algorithm, computed from the current accumulator
  logic [W:0]      mul_sum;
  logic [W:0]      div_shift;
  logic [W:0]      div_diff;

  // Sign-corrected results for FIX
  logic [2*W-1:0]  prod_fix;
  logic [W-1:0]    quo_fix;
  logic [W-1:0]    rem_fix;

`ifdef MULDIV_FAST_MUL_EN
  logic            fm_vld_q, fm_vld_d;
  logic [W-1:0]    fm_a_q, fm_a_d;
  logic [W-1:0]    fm_b_q, fm_b_d;
  logic            fm_neg_q, fm_neg_d;
  logic [2*W-1:0]  fm_prod;
  logic [2*W-1:0]  fm_fix;

  assign fm_prod = {{W{1'b0}}, fm_a_q} * {{W{1'b0}}, fm_b_q};
  assign fm_fix  = fm_neg_q ? -fm_prod : fm_prod;
`endif

  assign ready = (state_q == S_IDLE) && !flush;
  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

  assign op_mul    = (op == OP_MULT) || (op == OP_MULTU);
  assign op_div    = (op == OP_DIV)  || (op == OP_DIVU);
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign rs_neg    = op_signed & rs[W-1];
  assign rt_neg    = op_signed & rt[W-1];
  assign rs_mag    = rs_neg ? -rs : rs;
  assign rt_mag    = rt_neg ? -rt : rt;

  // Add the multiplicand into the high half when the current multiplier bit
  // is set; the carry becomes the new MSB after the right shift.
  assign mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});

  // Restoring step: bring the next dividend bit into the remainder and try
  // the subtraction; bit W of the difference is the borrow.
  assign div_shift = acc_q[2*W-1:W-1];
  assign div_diff  = div_shift - {1'b0, opb_q};

  assign prod_fix  = neg_q ? -acc_q : acc_q;
  assign quo_fix   = dbz_q ? {W{1'b1}} : (neg_q ? -acc_q[W-1:0] : acc_q[W-1:0]);
  assign rem_fix   = rneg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dbz_d    = dbz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
`ifdef MULDIV_FAST_MUL_EN
    fm_vld_d = 1'b0;
    fm_a_d   = fm_a_q;
    fm_b_d   = fm_b_q;
    fm_neg_d = fm_neg_q;

    // Multiply accepted last cycle lands now; a later mthi/mtlo accepted in
    // this same cycle is younger and overrides it below.
    if (fm_vld_q) begin
      hi_d   = fm_fix[2*W-1:W];
      lo_d   = fm_fix[W-1:0];
      done_d = 1'b1;
    end
`endif

    case (state_q)
      S_IDLE: begin
        if (start && ready) begin
          if (op_div) begin
            state_d  = S_CALC;
            cnt_d    = '0;
            acc_d    = {{W{1'b0}}, rs_mag};
            opb_d    = rt_mag;
            is_div_d = 1'b1;
            neg_d    = rs_neg ^ rt_neg;
            rneg_d   = rs_neg;
            dbz_d    = (rt == '0);
          end else if (op_mul) begin
`ifdef MULDIV_FAST_MUL_EN
            fm_vld_d = 1'b1;
            fm_a_d   = rs_mag;
            fm_b_d   = rt_mag;
            fm_neg_d = rs_neg ^ rt_neg;
`else
            state_d  = S_CALC;
            cnt_d    = '0;
            acc_d    = {{W{1'b0}}, rt_mag};
            opb_d    = rs_mag;
            is_div_d = 1'b0;
            neg_d    = rs_neg ^ rt_neg;
            rneg_d   = 1'b0;
            dbz_d    = 1'b0;
`endif
          end else if (op == OP_MTHI) begin
            hi_d = rs;
          end else if (op == OP_MTLO) begin
            lo_d = rt;
          end
          // reserved codes fall through: accepted, no effect
        end
      end

      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            if (!div_diff[W]) begin
              acc_d = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
            end else begin
              acc_d = {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
            end
          end else begin
            acc_d = {mul_sum, acc_q[W-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = S_FIX;
          end
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        // A flush arriving with the result discards it.
        if (!flush) begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*W-1:W];
            lo_d = prod_fix[W-1:0];
          end
          done_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dbz_q    <= dbz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fm_vld_q <= 1'b0;
      fm_a_q   <= '0;
      fm_b_q   <= '0;
      fm_neg_q <= 1'b0;
    end else begin
      fm_vld_q <= fm_vld_d;
      fm_a_q   <= fm_a_d;
      fm_b_q   <= fm_b_d;
      fm_neg_q <= fm_neg_d;
    end
  end
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  localparam int W   = 32;
  localparam int OPW = 3;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_RSV0  = 3'd6;
  localparam logic [2:0] OP_RSV1  = 3'd7;
  // Op used where an operation must stay in flight (iterative in both builds)
  localparam logic [2:0] LONG_OP  = FAST ? OP_DIVU : OP_MULTU;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [OPW-1:0] op;
  logic [W-1:0]   rs;
  logic [W-1:0]   rt;
  logic           flush;
  logic           ready;
  logic           busy;
  logic           done;
  logic [W-1:0]   hi;
  logic [W-1:0]   lo;

  muldiv_sequencer #(.DATA_WIDTH(W), .OP_WIDTH(OPW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .rs    (rs),
    .rt    (rt),
    .flush (flush),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  task automatic chk_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Move to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until the accepting edge (E0). Returns
  // 1 time unit after E0 with start dropped.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int guard;
    start = 1'b1;
    op    = o;
    rs    = a;
    rt    = b;
    guard = 0;
    while (ready !== 1'b1 && guard < 200) begin
      step();
      guard++;
    end
    chk_b("accept_ready", ready, 1'b1);
    step();
    start = 1'b0;
  endtask

  // Wait for done, counting edges after E0 and cycles with busy high.
  task automatic wait_done(output int lat, output int nbusy);
    lat   = 0;
    nbusy = 0;
    while (done !== 1'b1 && lat < W + 10) begin
      if (busy === 1'b1) nbusy++;
      step();
      lat++;
    end
  endtask

  task automatic count_dones(input int cycles, output int nd);
    nd = 0;
    for (int k = 0; k < cycles; k++) begin
      if (done === 1'b1) nd++;
      step();
    end
  endtask

  logic [W-1:0] cur_hi, cur_lo;
  int           lat, nbusy, nd, exp_lat, exp_busy;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{OP_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[1]  = '{OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14};
    vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000};
    vecs[4]  = '{OP_DIVU,  32'd42,        32'd0,        32'd42,        32'hFFFF_FFFF};
    vecs[5]  = '{OP_MTHI,  32'h1234_5678, 32'd0,        32'h1234_5678, 32'hFFFF_FFFF};
    vecs[6]  = '{OP_MTLO,  32'd0,         32'h9ABC_DEF0, 32'h1234_5678, 32'h9ABC_DEF0};
    vecs[7]  = '{OP_RSV0,  32'd1,         32'd1,        32'h1234_5678, 32'h9ABC_DEF0};
    vecs[8]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[9]  = '{OP_MULT,  32'd7,         32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6};
    vecs[10] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[11] = '{OP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3};
    vecs[12] = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[13] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
    vecs[14] = '{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0};
    vecs[15] = '{OP_MULTU, 32'hFFFF_FFFF, 32'd2,        32'd1,         32'hFFFF_FFFE};
    vecs[16] = '{OP_RSV1,  32'd5,         32'd5,        32'd1,         32'hFFFF_FFFE};
    vecs[17] = '{OP_DIVU,  32'd0,         32'd5,        32'd0,         32'd0};

    // Reset state
    rst_n = 1'b0;
    start = 1'b0;
    op    = '0;
    rs    = '0;
    rt    = '0;
    flush = 1'b0;
    #2;
    chk_w("reset_hi", hi, '0);
    chk_w("reset_lo", lo, '0);
    chk_b("reset_busy", busy, 1'b0);
    chk_b("reset_done", done, 1'b0);
    chk_b("reset_ready", ready, 1'b1);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Table: each request is issued the cycle the previous result is seen,
    // so the divide pairs also exercise back-to-back acceptance.
    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      chk_b($sformatf("v%0d_done_low_after_accept", i), done, 1'b0);
      if (vecs[i].op < 3'd4) begin
        exp_lat  = (FAST && vecs[i].op < 3'd2) ? 1 : W + 1;
        exp_busy = (FAST && vecs[i].op < 3'd2) ? 0 : W + 1;
        wait_done(lat, nbusy);
        chk_i($sformatf("v%0d_latency", i), lat, exp_lat);
        chk_i($sformatf("v%0d_busy_cycles", i), nbusy, exp_busy);
        chk_b($sformatf("v%0d_done", i), done, 1'b1);
        chk_b($sformatf("v%0d_ready_at_done", i), ready, 1'b1);
        chk_b($sformatf("v%0d_busy_at_done", i), busy, 1'b0);
      end else begin
        chk_b($sformatf("v%0d_busy", i), busy, 1'b0);
      end
      chk_w($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
      chk_w($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
    end
    step();
    chk_b("done_single_pulse", done, 1'b0);

    // Start while busy is ignored
    issue(OP_DIVU, 32'd12, 32'd1);
    for (int k = 0; k < 5; k++) step();
    start = 1'b1;
    op    = OP_MTHI;
    rs    = 32'hDEAD_BEEF;
    rt    = 32'd100;
    #0;
    chk_b("busy_start_ready", ready, 1'b0);
    for (int k = 0; k < 3; k++) step();
    start = 1'b0;
    chk_w("busy_start_hi_held", hi, 32'd0);
    chk_w("busy_start_lo_held", lo, 32'd0);
    wait_done(lat, nbusy);
    chk_i("busy_start_latency", lat + 8, W + 1);
    chk_w("busy_start_hi", hi, 32'd0);
    chk_w("busy_start_lo", lo, 32'd12);
    step();
    step();
    chk_w("busy_start_hi_after", hi, 32'd0);
    chk_w("busy_start_lo_after", lo, 32'd12);
    chk_b("busy_start_idle_after", busy, 1'b0);
    cur_hi = 32'd0;
    cur_lo = 32'd12;

    // Flush mid-operation
    issue(LONG_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int k = 0; k < 10; k++) step();
    flush = 1'b1;
    #0;
    chk_b("flush_calc_busy", busy, 1'b1);
    chk_b("flush_calc_ready", ready, 1'b0);
    step();
    flush = 1'b0;
    #0;
    chk_b("flush_calc_idle", busy, 1'b0);
    chk_b("flush_calc_ready_after", ready, 1'b1);
    count_dones(W + 5, nd);
    chk_i("flush_calc_no_done", nd, 0);
    chk_w("flush_calc_hi", hi, cur_hi);
    chk_w("flush_calc_lo", lo, cur_lo);

    // Flush coinciding with FIX drops the result
    issue(OP_DIVU, 32'd100, 32'd7);
    for (int k = 0; k < W; k++) step();
    chk_b("flush_fix_busy", busy, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk_b("flush_fix_done", done, 1'b0);
    chk_b("flush_fix_idle", busy, 1'b0);
    count_dones(4, nd);
    chk_i("flush_fix_no_done", nd, 0);
    chk_w("flush_fix_hi", hi, cur_hi);
    chk_w("flush_fix_lo", lo, cur_lo);

    // Flush in IDLE blocks acceptance
    flush = 1'b1;
    start = 1'b1;
    op    = OP_MTHI;
    rs    = 32'hDEAD_BEEF;
    #0;
    chk_b("flush_idle_ready", ready, 1'b0);
    step();
    start = 1'b0;
    flush = 1'b0;
    chk_w("flush_idle_hi", hi, cur_hi);

    // Asynchronous reset mid-operation
    issue(LONG_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int k = 0; k < 10; k++) step();
    rst_n = 1'b0;
    #1;
    chk_w("rst_mid_hi", hi, '0);
    chk_w("rst_mid_lo", lo, '0);
    chk_b("rst_mid_ready", ready, 1'b1);
    chk_b("rst_mid_busy", busy, 1'b0);
    chk_b("rst_mid_done", done, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    issue(OP_DIVU, 32'd9, 32'd4);
    wait_done(lat, nbusy);
    chk_i("post_rst_latency", lat, W + 1);
    chk_w("post_rst_hi", hi, 32'd1);
    chk_w("post_rst_lo", lo, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
